// File: rtl/regfile_pkg.sv
// Shared constants and FSM state encoding for the
// register-file loader.
package regfile_pkg;

  localparam int RF_DEPTH = 32;
  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_loader_if.sv
// Input stream plus register-file write/readback port.
// The loader holds the master side; source and regfile the slave side.
interface regfile_loader_if;
  import regfile_pkg::*;

  logic [RF_DW-1:0] InData;
  logic             InValid;
  logic             InReady;
  logic [RF_AW-1:0] WriteRegister;
  logic [RF_DW-1:0] WriteData;
  logic             RegWrite;
  logic [RF_AW-1:0] ReadRegister1;
  logic [RF_DW-1:0] ReadData1;

  modport master (
    input  InData, InValid, ReadData1,
    output InReady, WriteRegister, WriteData,
    output RegWrite, ReadRegister1
  );

  modport slave (
    output InData, InValid, ReadData1,
    input  InReady, WriteRegister, WriteData,
    input  RegWrite, ReadRegister1
  );

endinterface

// File: rtl/regfile_addr_next.sv
// Next write address: increment modulo the register count,
// optionally stepping over register 0.
module regfile_addr_next
  import regfile_pkg::*;
#(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic [RF_AW-1:0] addr_i,
  output logic [RF_AW-1:0] addr_o
);

  logic [RF_AW-1:0] inc;

  // wrap naturally at the address width, then skip zero if asked
  always_comb begin
    inc = addr_i + RF_AW'(1);
    if (SKIP_ZERO && inc == '0)
      addr_o = RF_AW'(1);
    else
      addr_o = inc;
  end

endmodule

// File: rtl/regfile_loader.sv
// Streams a job of words into consecutive registers and
// reads each one back the following cycle to verify it.
module regfile_loader
  import regfile_pkg::*;
#(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [RF_AW-1:0] BaseAddr,
  input  logic [5:0]       Count,
  regfile_loader_if.master rf,
  output logic             Busy,
  output logic             Done,
  output logic             Error,
  output logic [RF_AW-1:0] ErrAddr
);

  state_e           state_q, state_d;
  logic [RF_AW-1:0] addr_q, addr_d, addr_inc;
  logic [RF_AW-1:0] cmp_addr_q, cmp_addr_d;
  logic [RF_AW-1:0] err_addr_q, err_addr_d;
  logic [5:0]       rem_q, rem_d;
  logic [RF_DW-1:0] exp_q, exp_d;
  logic             cmp_vld_q, cmp_vld_d;
  logic             err_q, err_d;
  logic             in_ready, xfer, mism;

  regfile_addr_next #(
    .SKIP_ZERO (SKIP_ZERO)
  ) u_addr_next (
    .addr_i (addr_q),
    .addr_o (addr_inc)
  );

  assign xfer = in_ready & rf.InValid;
  assign mism = cmp_vld_q & (rf.ReadData1 != exp_q);

  assign rf.InReady       = in_ready;
  assign rf.RegWrite      = xfer;
  assign rf.WriteData     = rf.InData;
  assign rf.WriteRegister = addr_q;
  assign rf.ReadRegister1 = cmp_addr_q;
  assign Error            = err_q;
  assign ErrAddr          = err_addr_q;

  // state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // next-state: the last transfer goes through CHECK for its readback
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (Start)
                  state_d = (Count == 6'd0) ? ST_DONE : ST_LOAD;
      ST_LOAD:  if (xfer && rem_q == 6'd1)
                  state_d = ST_CHECK;
      ST_CHECK: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    in_ready = (state_q == ST_LOAD);
    Busy     = (state_q != ST_IDLE);
    Done     = (state_q == ST_DONE);
  end

  // job bookkeeping, readback pipeline and sticky error capture
  always_comb begin
    addr_d     = addr_q;
    rem_d      = rem_q;
    cmp_addr_d = cmp_addr_q;
    exp_d      = exp_q;
    cmp_vld_d  = xfer;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (state_q == ST_IDLE && Start) begin
      addr_d     = (SKIP_ZERO && BaseAddr == '0)
                   ? RF_AW'(1) : BaseAddr;
      rem_d      = Count;
      err_d      = 1'b0;
      err_addr_d = '0;
    end
    if (xfer) begin
      addr_d     = addr_inc;
      rem_d      = rem_q - 6'd1;
      cmp_addr_d = addr_q;
      exp_d      = (addr_q == '0) ? '0 : rf.InData;
    end
    if (mism && !err_q) begin
      err_d      = 1'b1;
      err_addr_d = cmp_addr_q;
    end
  end

  // datapath registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr_q     <= '0;
      rem_q      <= '0;
      cmp_addr_q <= '0;
      exp_q      <= '0;
      cmp_vld_q  <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      cmp_addr_q <= cmp_addr_d;
      exp_q      <= exp_d;
      cmp_vld_q  <= cmp_vld_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

endmodule
